spi_master: RTL

Parametrised successor to the 8/16-bit SPI engine. Full-duplex SPI master with selectable frame width (8/16/24/32 bits), all four CPOL/CPHA modes, a programmable SCLK divider and an integrated active-low chip select. It sits behind the peripheral register bank. The CPU writes configuration and `data_tx`, pulses `start`, then polls `busy` or catches `done`.

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_clk_div.sv | 33 +++
 rtl/spi_master.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encodings, frame-width
// encodings and the helper that turns a width code into a bit count.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LEAD  = 3'd2,
    TRAIL = 3'd3,
    HOLD  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    WIDTH_8  = 2'd0,
    WIDTH_16 = 2'd1,
    WIDTH_24 = 2'd2,
    WIDTH_32 = 2'd3
  } width_e;

  localparam int CNT_W = 6;

  // Frame length in bits for a width code.
  function automatic logic [CNT_W-1:0] width_bits(input logic [1:0] w);
    case (w)
      WIDTH_8:  return 6'd8;
      WIDTH_16: return 6'd16;
      WIDTH_24: return 6'd24;
      default:  return 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer for the SPI master. Reloaded on `load` with a new
// divisor, then counts down and emits a one-cycle `tick` every div+1 cycles.
module spi_clk_div #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 raw_clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;
  logic [DIV_WIDTH-1:0] reload;

  // Down-counter; the divisor is captured on load so later input changes are ignored.
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      reload <= '0;
    end else if (load) begin
      count  <= div;
      reload <= div;
    end else if (count == '0) begin
      count  <= reload;
    end else begin
      count  <= count - 1'b1;
    end
  end

  assign tick = (count == '0) && !load;

endmodule

// File: rtl/spi_master.sv
// Full-duplex SPI master with 8/16/24/32-bit frames, all four CPOL/CPHA
// modes, programmable SCLK divider and an integrated active-low chip select.
module spi_master
  import spi_pkg::*;
#(
  parameter int MAX_WIDTH = 32,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 raw_clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [1:0]           width,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic [MAX_WIDTH-1:0] data_tx,
  output logic [MAX_WIDTH-1:0] data_rx,
  output logic                 busy,
  output logic                 done,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 cs_n,
  input  logic                 miso
);

  state_e               state, next_state;
  logic [1:0]           width_q;
  logic                 cpol_q;
  logic                 cpha_q;
  logic [MAX_WIDTH-1:0] tx_sh;
  logic [MAX_WIDTH-1:0] rx_sh;
  logic [CNT_W-1:0]     bit_cnt;
  logic [MAX_WIDTH-1:0] data_rx_q;
  logic                 done_q;
  logic                 tick;
  logic                 accept;
  logic                 last_bit;
  logic [CNT_W-1:0]     shamt;

  // A start arriving in the done cycle is dropped so frames are always separated.
  assign accept   = (state == IDLE) && start && !done_q;
  assign last_bit = (bit_cnt == (width_bits(width_q) - 6'd1));
  assign shamt    = 6'(MAX_WIDTH) - width_bits(width);

  spi_clk_div #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_clk_div (
    .raw_clk(raw_clk),
    .reset_n(reset_n),
    .load   (accept),
    .div    (clk_div),
    .tick   (tick)
  );

  // State register.
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic and pin outputs decoded from the current state.
  always_comb begin
    next_state = state;
    sclk       = (state == LEAD) ? !cpol_q : cpol_q;
    cs_n       = (state == IDLE);
    busy       = (state != IDLE);
    mosi       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) next_state = SETUP;
      end
      SETUP: begin
        if (!cpha_q) mosi = tx_sh[MAX_WIDTH-1];
        if (tick) next_state = LEAD;
      end
      LEAD: begin
        mosi = tx_sh[MAX_WIDTH-1];
        if (tick) next_state = TRAIL;
      end
      TRAIL: begin
        mosi = tx_sh[MAX_WIDTH-1];
        if (tick) next_state = last_bit ? HOLD : LEAD;
      end
      HOLD: begin
        mosi = tx_sh[MAX_WIDTH-1];
        if (tick) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Configuration capture, shifters, bit counter and end-of-frame result.
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      width_q   <= 2'd0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      bit_cnt   <= '0;
      data_rx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) cpol_q <= cpol;
      if (accept) begin
        width_q <= width;
        cpha_q  <= cpha;
        tx_sh   <= data_tx << shamt;
        rx_sh   <= '0;
        bit_cnt <= '0;
      end else if (tick) begin
        case (state)
          SETUP: begin
            if (!cpha_q) rx_sh <= {rx_sh[MAX_WIDTH-2:0], miso};
          end
          LEAD: begin
            if (cpha_q)         rx_sh <= {rx_sh[MAX_WIDTH-2:0], miso};
            else if (!last_bit) tx_sh <= tx_sh << 1;
          end
          TRAIL: begin
            bit_cnt <= bit_cnt + 6'd1;
            if (!last_bit) begin
              if (cpha_q) tx_sh <= tx_sh << 1;
              else        rx_sh <= {rx_sh[MAX_WIDTH-2:0], miso};
            end
          end
          HOLD: begin
            data_rx_q <= rx_sh;
            done_q    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign data_rx = data_rx_q;
  assign done    = done_q;

endmodule
